// File: rtl/regfile_sb.sv
// Two-write, two-read register file with a per-register pending (busy) scoreboard.
// x0 is hardwired zero; reads bypass same-cycle writes, with port B taking priority.
module regfile_sb #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              ADDR_W   = 5,
    parameter logic [XLEN-1:0] SP_RESET = 32'h7FFFEFFC,
    parameter logic [XLEN-1:0] GP_RESET = 32'h10008000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    input  logic              wa_en_i,
    input  logic [ADDR_W-1:0] wa_addr_i,
    input  logic [XLEN-1:0]   wa_data_i,
    input  logic              wb_en_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              iss_valid_i,
    input  logic [ADDR_W-1:0] iss_rd_i,
    output logic              iss_ready_o,
    output logic [ADDR_W:0]   busy_cnt_o
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic [ADDR_W:0]  busy_cnt_q;
    logic [ADDR_W:0]  cnt_next;

    assign iss_ready_o = (iss_rd_i == '0) || !busy[iss_rd_i];
    assign busy_cnt_o  = busy_cnt_q;

    // A write clears the pending mark first; an accepted issue to the same register re-marks it.
    always_comb begin
        busy_next = busy;
        for (int i = 1; i < NREGS; i++) begin
            if ((wa_en_i && wa_addr_i == ADDR_W'(i)) || (wb_en_i && wb_addr_i == ADDR_W'(i)))
                busy_next[i] = 1'b0;
            if (iss_valid_i && iss_ready_o && iss_rd_i == ADDR_W'(i))
                busy_next[i] = 1'b1;
        end
        busy_next[0] = 1'b0;
        cnt_next = '0;
        for (int i = 0; i < NREGS; i++)
            cnt_next = cnt_next + (ADDR_W+1)'(busy_next[i]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            regs[2]    <= SP_RESET;
            regs[3]    <= GP_RESET;
            busy       <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wb_en_i && wb_addr_i == ADDR_W'(i))
                    regs[i] <= wb_data_i;
                else if (wa_en_i && wa_addr_i == ADDR_W'(i))
                    regs[i] <= wa_data_i;
            end
            busy       <= busy_next;
            busy_cnt_q <= cnt_next;
        end
    end

    always_comb begin
        rs1_data_o = regs[rs1_addr_i];
        rs1_busy_o = busy[rs1_addr_i];
        if (rs1_addr_i == '0) begin
            rs1_data_o = '0;
            rs1_busy_o = 1'b0;
        end else if (wb_en_i && wb_addr_i == rs1_addr_i) begin
            rs1_data_o = wb_data_i;
            rs1_busy_o = 1'b0;
        end else if (wa_en_i && wa_addr_i == rs1_addr_i) begin
            rs1_data_o = wa_data_i;
            rs1_busy_o = 1'b0;
        end
    end

    always_comb begin
        rs2_data_o = regs[rs2_addr_i];
        rs2_busy_o = busy[rs2_addr_i];
        if (rs2_addr_i == '0) begin
            rs2_data_o = '0;
            rs2_busy_o = 1'b0;
        end else if (wb_en_i && wb_addr_i == rs2_addr_i) begin
            rs2_data_o = wb_data_i;
            rs2_busy_o = 1'b0;
        end else if (wa_en_i && wa_addr_i == rs2_addr_i) begin
            rs2_data_o = wa_data_i;
            rs2_busy_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios then randomized traffic,
// checked against an array-based reference model of the register file and pending set.
module tb_regfile_sb;

    typedef struct packed {
        logic        rst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wa_en;
        logic [4:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        iss_valid;
        logic [4:0]  iss_rd;
    } stim_t;

    typedef struct packed {
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic        rs1_busy;
        logic        rs2_busy;
        logic        iss_ready;
        logic [5:0]  busy_cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        wa_en, wb_en;
    logic [4:0]  wa_addr, wb_addr;
    logic [31:0] wa_data, wb_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_ready;
    logic [5:0]  busy_cnt;

    int n_vectors = 0;
    int n_miscompares = 0;
    exp_t exp_q[$];

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    stim_t       cur;

    regfile_sb dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rs1_addr_i  (rs1_addr),
        .rs2_addr_i  (rs2_addr),
        .rs1_data_o  (rs1_data),
        .rs2_data_o  (rs2_data),
        .rs1_busy_o  (rs1_busy),
        .rs2_busy_o  (rs2_busy),
        .wa_en_i     (wa_en),
        .wa_addr_i   (wa_addr),
        .wa_data_i   (wa_data),
        .wb_en_i     (wb_en),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_data),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .iss_ready_o (iss_ready),
        .busy_cnt_o  (busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_regs[2] = 32'h7FFFEFFC;
        m_regs[3] = 32'h10008000;
    endfunction

    function automatic logic [31:0] model_read(input stim_t s, input logic [4:0] a);
        if (a == 5'd0)                   return 32'h0;
        if (s.wb_en && s.wb_addr == a)   return s.wb_data;
        if (s.wa_en && s.wa_addr == a)   return s.wa_data;
        return m_regs[a];
    endfunction

    function automatic logic model_src_busy(input stim_t s, input logic [4:0] a);
        if ((s.wa_en && s.wa_addr == a) || (s.wb_en && s.wb_addr == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [5:0] model_count();
        int c = 0;
        foreach (m_busy[i]) if (m_busy[i]) c++;
        return 6'(c);
    endfunction

    // The state change one clock edge produces, described as writes landing and the pending set changing.
    function automatic void model_commit(input stim_t s);
        logic accept;
        accept = s.iss_valid && (s.iss_rd == 5'd0 || !m_busy[s.iss_rd]);
        if (s.wa_en && s.wa_addr != 5'd0) begin
            m_regs[s.wa_addr] = s.wa_data;
            m_busy[s.wa_addr] = 1'b0;
        end
        if (s.wb_en && s.wb_addr != 5'd0) begin
            m_regs[s.wb_addr] = s.wb_data;
            m_busy[s.wb_addr] = 1'b0;
        end
        if (accept && s.iss_rd != 5'd0)
            m_busy[s.iss_rd] = 1'b1;
    endfunction

    task automatic applyStimulus(input stim_t s);
        exp_t e;
        @(posedge clk);
        if (!cur.rst) model_commit(cur);
        #1;
        rst       = s.rst;
        rs1_addr  = s.rs1;
        rs2_addr  = s.rs2;
        wa_en     = s.wa_en;
        wa_addr   = s.wa_addr;
        wa_data   = s.wa_data;
        wb_en     = s.wb_en;
        wb_addr   = s.wb_addr;
        wb_data   = s.wb_data;
        iss_valid = s.iss_valid;
        iss_rd    = s.iss_rd;
        cur = s;
        if (s.rst) model_reset();
        e.rs1_data  = model_read(s, s.rs1);
        e.rs2_data  = model_read(s, s.rs2);
        e.rs1_busy  = model_src_busy(s, s.rs1);
        e.rs2_busy  = model_src_busy(s, s.rs2);
        e.iss_ready = (s.iss_rd == 5'd0) || !m_busy[s.iss_rd];
        e.busy_cnt  = model_count();
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_miscompares++;
            $display("[TB] FAIL %s vector %0d: got %h, expected %h", name, n_vectors, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vectors++;
            checkOutput("rs1_data",  rs1_data,         e.rs1_data);
            checkOutput("rs2_data",  rs2_data,         e.rs2_data);
            checkOutput("rs1_busy",  32'(rs1_busy),    32'(e.rs1_busy));
            checkOutput("rs2_busy",  32'(rs2_busy),    32'(e.rs2_busy));
            checkOutput("iss_ready", 32'(iss_ready),   32'(e.iss_ready));
            checkOutput("busy_cnt",  32'(busy_cnt),    32'(e.busy_cnt));
        end
    end

    function automatic stim_t idle(input logic [4:0] a1, input logic [4:0] a2);
        stim_t s;
        s = '0;
        s.rs1 = a1;
        s.rs2 = a2;
        return s;
    endfunction

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        stim_t s;
        int drain;
        rst = 1'b1;
        rs1_addr = '0; rs2_addr = '0;
        wa_en = 1'b0; wa_addr = '0; wa_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
        cur = '0;
        cur.rst = 1'b1;
        model_reset();

        s = idle(5'd2, 5'd3); s.rst = 1'b1;
        applyStimulus(s);
        for (int i = 0; i < 32; i += 2)
            applyStimulus(idle(5'(i), 5'(i + 1)));

        // Same-cycle bypass of a port A write, then the stored value.
        s = idle(5'd5, 5'd0); s.wa_en = 1'b1; s.wa_addr = 5'd5; s.wa_data = 32'hDEADBEEF;
        applyStimulus(s);
        applyStimulus(idle(5'd5, 5'd0));

        s = idle(5'd7, 5'd7);
        s.wa_en = 1'b1; s.wa_addr = 5'd7; s.wa_data = 32'h1111;
        s.wb_en = 1'b1; s.wb_addr = 5'd7; s.wb_data = 32'h2222;
        applyStimulus(s);
        s = idle(5'd7, 5'd0); s.wa_en = 1'b1; s.wa_addr = 5'd0; s.wa_data = 32'hCAFEF00D;
        applyStimulus(s);
        applyStimulus(idle(5'd7, 5'd0));

        // Issue, WAW stall, clearing write, and the freed register.
        s = idle(5'd9, 5'd0); s.iss_valid = 1'b1; s.iss_rd = 5'd9;
        applyStimulus(s);
        applyStimulus(s);
        s = idle(5'd9, 5'd9); s.iss_rd = 5'd9; s.wb_en = 1'b1; s.wb_addr = 5'd9; s.wb_data = 32'h99;
        applyStimulus(s);
        s = idle(5'd9, 5'd0); s.iss_rd = 5'd9;
        applyStimulus(s);

        s = idle(5'd4, 5'd0); s.iss_valid = 1'b1; s.iss_rd = 5'd4;
        s.wa_en = 1'b1; s.wa_addr = 5'd4; s.wa_data = 32'h44444444;
        applyStimulus(s);
        s = idle(5'd4, 5'd0); s.iss_valid = 1'b1; s.iss_rd = 5'd0;
        applyStimulus(s);
        applyStimulus(idle(5'd4, 5'd0));

        // Mid-cycle reset with several registers pending and x2/x3 overwritten.
        s = idle(5'd0, 5'd0);
        s.wa_en = 1'b1; s.wa_addr = 5'd2; s.wa_data = 32'h12345678;
        s.wb_en = 1'b1; s.wb_addr = 5'd3; s.wb_data = 32'h87654321;
        applyStimulus(s);
        for (int r = 10; r < 13; r++) begin
            s = idle(5'd2, 5'd3); s.iss_valid = 1'b1; s.iss_rd = 5'(r);
            applyStimulus(s);
        end
        applyStimulus(idle(5'd10, 5'd12));
        s = idle(5'd10, 5'd11); s.rst = 1'b1;
        applyStimulus(s);
        s = idle(5'd2, 5'd3); s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(idle(5'd12, 5'd4));

        for (int n = 0; n < 600; n++) begin
            s = '0;
            s.rs1       = rand_addr();
            s.rs2       = rand_addr();
            s.iss_valid = ($urandom_range(0, 1) == 1);
            s.iss_rd    = rand_addr();
            if ($urandom_range(0, 63) == 0) begin
                s.rst = 1'b1;
                s.iss_valid = 1'b0;
            end else begin
                s.wa_en   = ($urandom_range(0, 2) == 0);
                s.wa_addr = rand_addr();
                s.wa_data = $urandom;
                s.wb_en   = ($urandom_range(0, 2) == 0);
                s.wb_addr = ($urandom_range(0, 3) == 0) ? s.wa_addr : rand_addr();
                s.wb_data = $urandom;
            end
            applyStimulus(s);
        end
        applyStimulus(idle(5'd1, 5'd2));

        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        if (exp_q.size() != 0) begin
            n_miscompares++;
            $display("[TB] FAIL drain: %0d vectors left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation reached %0t, expected to finish earlier", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
